// File: rtl/miinst_issue_queue.sv
// Micro-instruction issue queue: accepts NOP-compacted bundles from fetch and
// issues one entry per cycle in arrival/slot order, with backpressure and flush.
`ifndef MQ_N
`define MQ_N 4
`endif

package miinst_pkg;
  typedef enum logic [4:0] {
    MIOP_NOP  = 5'd0,
    MIOP_ADD  = 5'd1,
    MIOP_ADDI = 5'd2,
    MIOP_L    = 5'd3,
    MIOP_MOV  = 5'd4,
    MIOP_S    = 5'd5,
    MIOP_BR   = 5'd6
  } miop_e;

  typedef struct packed {
    miop_e       op;
    logic [4:0]  d;
    logic [4:0]  s;
    logic [4:0]  t;
    logic [15:0] imm;
    logic [1:0]  bmd;
    logic [31:0] pc;
  } miinst_t;
endpackage

module miinst_issue_queue
  import miinst_pkg::*;
#(
  parameter int MQ_N  = `MQ_N,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         bundle_valid,
  input  miinst_t [MQ_N-1:0]           bundle,
  output logic                         bundle_ready,
  output logic                         issue_valid,
  output miinst_t                      issue_miinst,
  input  logic                         issue_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  miinst_t         mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   off [MQ_N];
  logic [CW-1:0]   k;
  logic            accept;
  logic            pop;

  // Readiness deliberately ignores NOP slots and a same-cycle pop so it never
  // depends on bundle contents.
  assign bundle_ready = ((CW'(DEPTH) - count) >= CW'(MQ_N)) & ~flush;
  assign issue_valid  = (count != '0) & ~flush;
  assign issue_miinst = mem[rd_ptr];
  assign accept       = bundle_valid & bundle_ready;
  assign pop          = issue_valid & issue_ready;

  // Prefix count of non-NOP slots gives each live slot its compacted offset.
  always_comb begin
    k = '0;
    for (int i = 0; i < MQ_N; i++) begin
      off[i] = k;
      if (bundle[i].op != MIOP_NOP) begin
        k = k + CW'(1);
      end else begin
        k = k;
      end
    end
  end

  // Storage is intentionally unreset; only pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < MQ_N; i++) begin
        if (bundle[i].op != MIOP_NOP) begin
          mem[wr_ptr + PW'(off[i])] <= bundle[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PW'(k);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + (accept ? k : CW'(0)) - (pop ? CW'(1) : CW'(0));
    end
  end

endmodule

// File: tb/tb_miinst_issue_queue.sv
// Scoreboard bench for miinst_issue_queue: stimulus pushes expected issues,
// a negedge monitor pops and compares every handshake on the issue port.
module tb_miinst_issue_queue;
  import miinst_pkg::*;

  localparam int MQ_N  = 4;
  localparam int DEPTH = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               flush = 1'b0;
  logic               bundle_valid = 1'b0;
  miinst_t [MQ_N-1:0] bundle = '0;
  logic               bundle_ready;
  logic               issue_valid;
  miinst_t            issue_miinst;
  logic               issue_ready = 1'b0;
  logic [3:0]         count;

  int checks = 0;
  int errors = 0;
  miinst_t sb[$];

  miinst_issue_queue #(.MQ_N(MQ_N), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .bundle_valid(bundle_valid), .bundle(bundle), .bundle_ready(bundle_ready),
    .issue_valid(issue_valid), .issue_miinst(issue_miinst),
    .issue_ready(issue_ready), .count(count)
  );

  always #5 clk = ~clk;

  function automatic miinst_t mk(input miop_e op, input logic [31:0] pc);
    miinst_t m;
    m.op  = op;
    m.d   = pc[6:2];
    m.s   = pc[7:3] ^ 5'd1;
    m.t   = pc[8:4] ^ 5'd2;
    m.imm = pc[15:0] ^ 16'hA5A5;
    m.bmd = pc[3:2];
    m.pc  = pc;
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a bundle, wait (bounded) for readiness, log expected issues on accept.
  task automatic send(input miinst_t [MQ_N-1:0] b);
    int n;
    n = 0;
    bundle = b;
    bundle_valid = 1'b1;
    #1;
    while (!bundle_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bundle_ready) begin
      chk("send_timeout", 64'(bundle_ready), 64'd1);
    end else begin
      for (int i = 0; i < MQ_N; i++) begin
        if (b[i].op != MIOP_NOP) sb.push_back(b[i]);
      end
    end
    tick();
    bundle_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    issue_ready = 1'b1;
    while (count != 4'd0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain_count", 64'(count), 64'd0);
    issue_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && issue_valid && issue_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected actual=%h expected=none", issue_miinst);
      end else begin
        miinst_t e;
        e = sb.pop_front();
        if (issue_miinst !== e) begin
          errors++;
          $display("FAIL issue_order actual=%h expected=%h", issue_miinst, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    miinst_t [MQ_N-1:0] b;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(bundle_ready), 64'd1);
    chk("rst_valid", 64'(issue_valid), 64'd0);

    // single bundle
    issue_ready = 1'b1;
    b = {mk(MIOP_NOP, 32'h0), mk(MIOP_NOP, 32'h0), mk(MIOP_NOP, 32'h0), mk(MIOP_ADD, 32'h100)};
    send(b);
    chk("t1_valid", 64'(issue_valid), 64'd1);
    chk("t1_op", 64'(issue_miinst.op), 64'(MIOP_ADD));
    chk("t1_pc", 64'(issue_miinst.pc), 64'h100);
    tick();
    chk("t1_empty_valid", 64'(issue_valid), 64'd0);
    chk("t1_empty_count", 64'(count), 64'd0);

    // compaction
    issue_ready = 1'b0;
    b = {mk(MIOP_MOV, 32'h20C), mk(MIOP_ADDI, 32'h208), mk(MIOP_NOP, 32'h204), mk(MIOP_L, 32'h200)};
    send(b);
    chk("t2_count", 64'(count), 64'd3);
    issue_ready = 1'b1;
    tick(); tick(); tick();
    chk("t2_drained", 64'(count), 64'd0);
    chk("t2_valid", 64'(issue_valid), 64'd0);
    issue_ready = 1'b0;

    // full / backpressure across the wrap
    b = {mk(MIOP_ADD, 32'h30C), mk(MIOP_ADD, 32'h308), mk(MIOP_ADD, 32'h304), mk(MIOP_ADD, 32'h300)};
    send(b);
    b = {mk(MIOP_L, 32'h31C), mk(MIOP_S, 32'h318), mk(MIOP_MOV, 32'h314), mk(MIOP_ADDI, 32'h310)};
    send(b);
    chk("t3_full_count", 64'(count), 64'd8);
    chk("t3_full_ready", 64'(bundle_ready), 64'd0);
    b = {mk(MIOP_BR, 32'h32C), mk(MIOP_ADD, 32'h328), mk(MIOP_L, 32'h324), mk(MIOP_MOV, 32'h320)};
    bundle = b;
    bundle_valid = 1'b1;
    tick(); tick();
    chk("t3_held_ready", 64'(bundle_ready), 64'd0);
    chk("t3_held_count", 64'(count), 64'd8);
    issue_ready = 1'b1;
    send(b);
    chk("t3_after_accept", 64'(count), 64'd7);
    drain();

    // simultaneous accept and pop
    b = {mk(MIOP_NOP, 32'h0), mk(MIOP_NOP, 32'h0), mk(MIOP_ADDI, 32'h404), mk(MIOP_MOV, 32'h400)};
    send(b);
    chk("t4_start", 64'(count), 64'd2);
    for (int it = 0; it < 3; it++) begin
      issue_ready = 1'b1;
      b = {mk(MIOP_MOV, 32'h41C + 32'(it*16)), mk(MIOP_L, 32'h418 + 32'(it*16)),
           mk(MIOP_ADD, 32'h414 + 32'(it*16)), mk(MIOP_NOP, 32'h0)};
      send(b);
      chk("t4_acc_pop", 64'(count), 64'd4);
      tick(); tick();
      issue_ready = 1'b0;
      #1;
      chk("t4_after_pops", 64'(count), 64'd2);
    end
    drain();

    // flush
    b = {mk(MIOP_S, 32'h50C), mk(MIOP_L, 32'h508), mk(MIOP_ADD, 32'h504), mk(MIOP_MOV, 32'h500)};
    send(b);
    b = {mk(MIOP_S, 32'h510), mk(MIOP_NOP, 32'h0), mk(MIOP_NOP, 32'h0), mk(MIOP_NOP, 32'h0)};
    send(b);
    chk("t5_count", 64'(count), 64'd5);
    b = {mk(MIOP_ADD, 32'h52C), mk(MIOP_ADD, 32'h528), mk(MIOP_ADD, 32'h524), mk(MIOP_ADD, 32'h520)};
    bundle = b;
    bundle_valid = 1'b1;
    flush = 1'b1;
    issue_ready = 1'b1;
    #1;
    chk("t5_flush_valid", 64'(issue_valid), 64'd0);
    chk("t5_flush_ready", 64'(bundle_ready), 64'd0);
    sb.delete();
    tick();
    flush = 1'b0;
    bundle_valid = 1'b0;
    issue_ready = 1'b0;
    #1;
    chk("t5_post_count", 64'(count), 64'd0);
    chk("t5_post_valid", 64'(issue_valid), 64'd0);
    b = {mk(MIOP_NOP, 32'h0), mk(MIOP_NOP, 32'h0), mk(MIOP_BR, 32'h600), mk(MIOP_NOP, 32'h0)};
    send(b);
    chk("t5_new_count", 64'(count), 64'd1);
    chk("t5_new_pc", 64'(issue_miinst.pc), 64'h600);
    drain();

    // all-NOP bundle and asynchronous reset
    b = {mk(MIOP_NOP, 32'h0), mk(MIOP_NOP, 32'h0), mk(MIOP_NOP, 32'h0), mk(MIOP_NOP, 32'h0)};
    send(b);
    chk("t6_nop_count0", 64'(count), 64'd0);
    chk("t6_nop_valid", 64'(issue_valid), 64'd0);
    b = {mk(MIOP_NOP, 32'h0), mk(MIOP_ADDI, 32'h708), mk(MIOP_S, 32'h704), mk(MIOP_L, 32'h700)};
    send(b);
    chk("t6_count3", 64'(count), 64'd3);
    b = {mk(MIOP_NOP, 32'h0), mk(MIOP_NOP, 32'h0), mk(MIOP_NOP, 32'h0), mk(MIOP_NOP, 32'h0)};
    send(b);
    chk("t6_nop_count3", 64'(count), 64'd3);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_count", 64'(count), 64'd0);
    chk("t6_async_valid", 64'(issue_valid), 64'd0);
    sb.delete();
    tick();
    reset = 1'b0;
    b = {mk(MIOP_MOV, 32'h80C), mk(MIOP_NOP, 32'h0), mk(MIOP_ADD, 32'h804), mk(MIOP_NOP, 32'h0)};
    send(b);
    chk("t6_post_reset_count", 64'(count), 64'd2);
    drain();
    tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
